// File: rtl/max_det_feeder_pkg.sv
// Shared definitions for the max_det_feeder slice.
//   feeder_state_e : pacing FSM states (IDLE, LEAD, SLOT, GAP)
//   DATA_W_DEF     : default sample width, equal to the detector inpB width
//   FRAME_LEN_W    : width of the frame sample counter and frame_len output
//   sat_inc()      : saturating increment for the frame sample counter
package max_det_feeder_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int FRAME_LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        SLOT = 2'd2,
        GAP  = 2'd3
    } feeder_state_e;

    // Sticks at all-ones instead of wrapping to zero.
    function automatic logic [FRAME_LEN_W-1:0] sat_inc(input logic [FRAME_LEN_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/max_det_feeder_if.sv
// Sample stream into the feeder (valid/ready with an end-of-frame marker).
//   s_valid : sample valid
//   s_ready : feeder can accept a sample this cycle
//   s_data  : sample value
//   s_last  : sample closes the current frame
// Modports: master = upstream source, slave = the feeder.
interface max_det_feeder_if
    import max_det_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/max_det_feeder_sync_fifo.sv
// Show-ahead synchronous FIFO.
//   clk, reset : clock, asynchronous active-high reset (pointers only)
//   push, din  : write din when push && !full
//   pop        : drop the head when pop && !empty
//   dout       : current head, combinational
//   dout_next  : entry behind the head, combinational (valid when has_next)
//   full/empty : occupancy flags
//   has_next   : at least two entries are stored
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] dout_next,
    output logic             full,
    output logic             empty,
    output logic             has_next
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_nxt;

    assign rd_ptr_nxt = rd_ptr + 1'b1;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign has_next   = !empty && (rd_ptr_nxt != wr_ptr);
    assign dout       = mem[rd_ptr[AW-1:0]];
    assign dout_next  = mem[rd_ptr_nxt[AW-1:0]];

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and a reset-free array maps onto RAM.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr_nxt;
        end
    end
endmodule

// File: rtl/max_det_feeder.sv
// Upstream feeder for the ALU-based largest-value detector.
// Buffers a valid/ready sample stream and paces the detector's dv/inpB pair:
// one lead slot for the detector's IDLE->LOAD step, each sample held for a
// LOAD/WAIT/STORE slot, and dv dropped after every frame so the detector
// reports the frame maximum.
//   clk, reset  : clock, asynchronous active-high reset
//   s           : sample stream (slave modport)
//   dv          : data valid to detector, registered
//   data_out    : sample to detector inpB, registered
//   frame_done  : 1-cycle pulse on the first GAP cycle
//   frame_len   : sample count of the last completed frame (saturating)
//   underrun    : 1-cycle pulse when a slot ends with no next sample buffered
module max_det_feeder
    import max_det_feeder_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int SLOT_CYC   = 3,
    parameter int LEAD_CYC   = 1,
    parameter int GAP_CYC    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    max_det_feeder_if.slave        s,
    output logic                   dv,
    output logic [DATA_W-1:0]      data_out,
    output logic                   frame_done,
    output logic [FRAME_LEN_W-1:0] frame_len,
    output logic                   underrun
);
    localparam int CNT_MAX = (LEAD_CYC > SLOT_CYC)
                           ? ((LEAD_CYC > GAP_CYC) ? LEAD_CYC : GAP_CYC)
                           : ((SLOT_CYC > GAP_CYC) ? SLOT_CYC : GAP_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SLOT_INIT = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LEAD_INIT = (LEAD_CYC > 0) ? CNT_W'(LEAD_CYC - 1) : '0;

    feeder_state_e          state;
    logic [CNT_W-1:0]       cnt;
    logic [FRAME_LEN_W-1:0] count;
    logic                   cur_last;   // last flag of the sample on data_out

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_has_next;
    logic [DATA_W:0]   fifo_dout;
    logic [DATA_W:0]   fifo_next;
    logic              slot_end;

    assign s.s_ready = !fifo_full;
    assign fifo_push = s.s_valid && !fifo_full;
    assign slot_end  = (state == SLOT) && (cnt == '0);
    // The head stays buffered for its whole slot and is popped only when it
    // is retired; an underrun leaves it in place so it is replayed.
    assign fifo_pop  = slot_end && (cur_last || fifo_has_next);

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .din       ({s.s_last, s.s_data}),
        .dout      (fifo_dout),
        .dout_next (fifo_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .has_next  (fifo_has_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            count      <= '0;
            cur_last   <= 1'b0;
            dv         <= 1'b0;
            data_out   <= '0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        dv                   <= 1'b1;
                        {cur_last, data_out} <= fifo_dout;
                        if (LEAD_CYC == 0) begin
                            state <= SLOT;
                            cnt   <= SLOT_INIT;
                        end else begin
                            state <= LEAD;
                            cnt   <= LEAD_INIT;
                        end
                    end
                end
                LEAD: begin
                    if (cnt == '0) begin
                        state <= SLOT;
                        cnt   <= SLOT_INIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SLOT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (cur_last) begin
                        state      <= GAP;
                        cnt        <= GAP_INIT;
                        dv         <= 1'b0;
                        frame_done <= 1'b1;
                        frame_len  <= sat_inc(count);
                        count      <= '0;
                    end else if (fifo_has_next) begin
                        {cur_last, data_out} <= fifo_next;
                        count                <= sat_inc(count);
                        cnt                  <= SLOT_INIT;
                    end else begin
                        // Replaying the same sample cannot change the maximum.
                        underrun <= 1'b1;
                        cnt      <= SLOT_INIT;
                    end
                end
                GAP: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
            endcase
        end
    end
endmodule
